interval_timer_ctrl: RTL and testbench
======================================

Name: interval_timer_ctrl

Overview:
- Programmable interval timer and time-parameter store for the traffic light controller.
- Holds the base, extended and yellow durations and accepts writes from the program strobe.
- Times the interval the FSM selects (interval, start_timer) and returns a one-cycle expired pulse.
- Sits between the FSM and the synchronised user inputs; owns the one-second prescaler.

Parameters:
CLK_PER_SEC, 4, clk cycles per one-second tick (4 for simulation; board value set at instantiation, must be >=2)
VAL_W, 4, width of time values in seconds
DEF_BASE, 6, reset/default base interval (s)
DEF_EXT, 3, reset/default extended interval (s)
DEF_YEL, 2, reset/default yellow interval (s)

Ports:
clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Prog_Sync  in  1  synchronised program strobe; writes Value into the register selected by Sel
Sel  in  2  parameter select: 00 base, 01 extended, 10 yellow, 11 reserved
Value  in  VAL_W  time value to program (s)
interval  in  2  interval requested by FSM: 00 base, 01 extended, 10 yellow, 11 treated as base
start_timer  in  1  load and start the countdown for interval
expired  out  1  one-cycle pulse at end of countdown
Busy  out  1  high while counting
Sec_Tick  out  1  one-cycle pulse at each one-second boundary while counting
Remaining  out  VAL_W  seconds left in current countdown

Behaviour:
- Reset (Reset_n low, asynchronous): base/ext/yel <= DEF_BASE/DEF_EXT/DEF_YEL; prescaler 0; Remaining 0; state IDLE; expired, Busy, Sec_Tick 0.
- Parameter write on an edge with Prog_Sync=1:
  - Selected register <= Value.
  - Value==0 loads that register's default instead.
  - Sel=11: no register change.
  - Any in-flight countdown aborts: state IDLE, Busy 0, Remaining 0, no expired.
- States: IDLE, COUNT. All outputs registered.
- Priority per edge: Prog_Sync > start_timer > count step.
- Start (edge with start_timer=1, Prog_Sync=0, any state):
  - Remaining <= param[interval]; prescaler <= 0; state COUNT; Busy 1.
  - interval is sampled only here; changes during COUNT are ignored.
  - Restart mid-count reloads; the old countdown produces no expired.
- COUNT step:
  - Each edge, prescaler increments.
  - When prescaler==CLK_PER_SEC-1: prescaler wraps to 0, Remaining decrements, Sec_Tick pulses for 1 cycle.
  - If that decrement reaches 0: expired <= 1 for exactly 1 cycle, state IDLE, Busy 0.
- Latency: start sampled at edge t0 with value N -> expired high from edge t0+N*CLK_PER_SEC for one cycle.
- Simultaneous start_timer and final tick: restart wins, expired not asserted.
- Outside a count, expired and Sec_Tick are 0. IDLE holds Remaining 0.
- Reset asserted mid-count: immediate return to reset values; the parameter registers revert to defaults.

Test Plan:
- Default timing (CLK_PER_SEC=4): release reset, pulse start_timer with interval=00 -> Busy 1, Remaining 6,5..1; expired single pulse exactly 24 cycles after start edge; Sec_Tick pulses 6 times.
- Programming: Prog_Sync, Sel=10, Value=5, then start with interval=10 -> expired after 20 cycles. Program Sel=01 Value=0, start interval=01 -> 3 s (12 cycles) default restored. Sel=11 -> no register changes.
- Restart/abort:
  - Start base, re-pulse start_timer after 9 cycles with interval=10 -> Remaining reloads to 2, expired 8 cycles after second start, no earlier pulse.
  - Prog_Sync mid-count -> Busy drops next edge, no expired.
- Boundary collisions:
  - start_timer on the same edge as the final tick -> no expired that cycle, new countdown runs.
  - Prog_Sync and start_timer same edge -> timer stays IDLE.
  - interval=11 -> times as base (6 s).
- Async reset: assert Reset_n low mid-count between edges -> expired/Busy/Remaining/Sec_Tick 0 immediately; programmed values revert to 6/3/2.
- Back-to-back: start on the cycle expired is high -> new countdown starts cleanly; expired is exactly one cycle wide; max Value=15 -> 60 cycles.

Source files
------------

// File: rtl/interval_timer_ctrl_if.sv
// ============================================================================
// Module   : interval_timer_ctrl_if
// Brief    : Handshake bundle between the light-sequence FSM and the interval
//            timer: parameter programming, timer start and timer status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interval_timer_ctrl_if #(
  parameter int VAL_W = 4
) ();
  logic             Prog_Sync;
  logic [1:0]       Sel;
  logic [VAL_W-1:0] Value;
  logic [1:0]       interval;
  logic             start_timer;
  logic             expired;
  logic             Busy;
  logic             Sec_Tick;
  logic [VAL_W-1:0] Remaining;

  modport master (
    output Prog_Sync, Sel, Value, interval, start_timer,
    input  expired, Busy, Sec_Tick, Remaining
  );

  modport slave (
    input  Prog_Sync, Sel, Value, interval, start_timer,
    output expired, Busy, Sec_Tick, Remaining
  );
endinterface

`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
// ============================================================================
// Module   : interval_timer_ctrl
// Brief    : Programmable interval timer with base/extended/yellow duration
//            store and one-second prescaler for the traffic light controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interval_timer_ctrl #(
  parameter int CLK_PER_SEC = 4,
  parameter int VAL_W       = 4,
  parameter int DEF_BASE    = 6,
  parameter int DEF_EXT     = 3,
  parameter int DEF_YEL     = 2
) (
  input  wire logic          clk,
  input  wire logic          Reset_n,
  interval_timer_ctrl_if.slave bus
);

  localparam int               c_PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(CLK_PER_SEC - 1);
  localparam logic [c_PW-1:0]  c_PRESC_ONE  = c_PW'(1);
  localparam logic [VAL_W-1:0] c_DEF_BASE   = VAL_W'(DEF_BASE);
  localparam logic [VAL_W-1:0] c_DEF_EXT    = VAL_W'(DEF_EXT);
  localparam logic [VAL_W-1:0] c_DEF_YEL    = VAL_W'(DEF_YEL);
  localparam logic [VAL_W-1:0] c_VAL_ZERO   = '0;
  localparam logic [VAL_W-1:0] c_VAL_ONE    = VAL_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [c_PW-1:0]  r_presc,     w_presc_nxt;
  logic [VAL_W-1:0] r_remaining, w_remaining_nxt;
  logic [VAL_W-1:0] r_base,      w_base_nxt;
  logic [VAL_W-1:0] r_ext,       w_ext_nxt;
  logic [VAL_W-1:0] r_yel,       w_yel_nxt;
  logic             r_expired,   w_expired_nxt;
  logic             r_sec_tick,  w_sec_tick_nxt;
  logic             r_busy;
  logic [VAL_W-1:0] w_sel_param;
  logic             w_value_zero;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_base      <= c_DEF_BASE;
      r_ext       <= c_DEF_EXT;
      r_yel       <= c_DEF_YEL;
      r_expired   <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_remaining <= w_remaining_nxt;
      r_base      <= w_base_nxt;
      r_ext       <= w_ext_nxt;
      r_yel       <= w_yel_nxt;
      r_expired   <= w_expired_nxt;
      r_sec_tick  <= w_sec_tick_nxt;
      r_busy      <= (w_state_nxt == COUNT);
    end
  end

  // Interval code 11 is not a real phase; it falls back to the base duration.
  always_comb begin
    w_sel_param = r_base;
    case (bus.interval)
      2'b01:   w_sel_param = r_ext;
      2'b10:   w_sel_param = r_yel;
      default: w_sel_param = r_base;
    endcase
  end

  assign w_value_zero = (bus.Value == c_VAL_ZERO);

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_remaining_nxt = r_remaining;
    w_base_nxt      = r_base;
    w_ext_nxt       = r_ext;
    w_yel_nxt       = r_yel;
    w_expired_nxt   = 1'b0;
    w_sec_tick_nxt  = 1'b0;

    if (bus.Prog_Sync) begin
      // Reprogramming invalidates any running interval, so the count is dropped.
      case (bus.Sel)
        2'b00:   w_base_nxt = w_value_zero ? c_DEF_BASE : bus.Value;
        2'b01:   w_ext_nxt  = w_value_zero ? c_DEF_EXT  : bus.Value;
        2'b10:   w_yel_nxt  = w_value_zero ? c_DEF_YEL  : bus.Value;
        default: ;
      endcase
      w_state_nxt     = IDLE;
      w_presc_nxt     = '0;
      w_remaining_nxt = '0;
    end else if (bus.start_timer) begin
      w_state_nxt     = COUNT;
      w_presc_nxt     = '0;
      w_remaining_nxt = w_sel_param;
    end else if (r_state == COUNT) begin
      if (r_presc == c_PRESC_LAST) begin
        w_presc_nxt     = '0;
        w_sec_tick_nxt  = 1'b1;
        // A zero load would otherwise wrap; treat it as finishing on this tick.
        if (r_remaining <= c_VAL_ONE) begin
          w_remaining_nxt = '0;
          w_expired_nxt   = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_remaining_nxt = r_remaining - c_VAL_ONE;
        end
      end else begin
        w_presc_nxt = r_presc + c_PRESC_ONE;
      end
    end
  end

  assign bus.expired   = r_expired;
  assign bus.Busy      = r_busy;
  assign bus.Sec_Tick  = r_sec_tick;
  assign bus.Remaining = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
// ============================================================================
// Module   : tb_interval_timer_ctrl
// Brief    : Directed self-checking bench for interval_timer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interval_timer_ctrl;

  localparam int CPS = 4;
  localparam int VW  = 4;

  logic clk;
  logic Reset_n;
  int   checks;
  int   errors;

  interval_timer_ctrl_if #(.VAL_W(VW)) bus ();

  interval_timer_ctrl #(
    .CLK_PER_SEC (CPS),
    .VAL_W       (VW),
    .DEF_BASE    (6),
    .DEF_EXT     (3),
    .DEF_YEL     (2)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic prog(input logic [1:0] sel, input logic [VW-1:0] val);
    bus.Prog_Sync = 1'b1;
    bus.Sel       = sel;
    bus.Value     = val;
    cyc(1);
    bus.Prog_Sync = 1'b0;
  endtask

  task automatic start(input logic [1:0] iv);
    bus.start_timer = 1'b1;
    bus.interval    = iv;
    cyc(1);
    bus.start_timer = 1'b0;
  endtask

  // Called just after the start edge; returns just after the expired edge.
  task automatic measure(input string tag, input int n);
    int cnt;
    int ticks;
    bit bad;
    bit seen;
    cnt = 0; ticks = 0; bad = 0; seen = 0;
    while (!seen && cnt < 200) begin
      cyc(1);
      cnt++;
      if (bus.Sec_Tick === 1'b1) ticks++;
      if (bus.expired === 1'b1) seen = 1;
      else if (bus.Remaining !== VW'(n - cnt / CPS) || bus.Busy !== 1'b1) bad = 1;
    end
    chk({tag, "_latency"}, cnt, n * CPS);
    chk({tag, "_ticks"}, ticks, n);
    chk({tag, "_rem_seq_bad"}, {31'd0, bad}, 0);
    chk({tag, "_done_busy_rem"}, {bus.Busy, bus.Remaining}, 0);
  endtask

  task automatic no_expire(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (bus.expired !== 1'b0) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_n         = 1'b0;
    bus.Prog_Sync   = 1'b0;
    bus.Sel         = 2'b00;
    bus.Value       = '0;
    bus.interval    = 2'b00;
    bus.start_timer = 1'b0;

    #2;
    chk("reset_outputs", {bus.expired, bus.Busy, bus.Sec_Tick, bus.Remaining}, 0);
    #20;
    Reset_n = 1'b1;
    cyc(1);
    chk("idle_after_reset", {bus.Busy, bus.Remaining}, 0);

    // Default base interval
    start(2'b00);
    chk("base_start_busy_rem", {bus.Busy, bus.Remaining}, {1'b1, 4'd6});
    measure("base", 6);
    cyc(1);
    chk("expired_width", bus.expired, 0);

    // Program yellow to 5
    prog(2'b10, 4'd5);
    start(2'b10);
    measure("yel5", 5);

    // Value 0 restores ext default
    prog(2'b01, 4'd0);
    start(2'b01);
    chk("ext_def_rem", bus.Remaining, 3);
    measure("ext_def", 3);

    // Reserved select changes nothing
    prog(2'b11, 4'd9);
    start(2'b00);
    chk("sel11_base", bus.Remaining, 6);
    start(2'b01);
    chk("sel11_ext", bus.Remaining, 3);
    start(2'b10);
    chk("sel11_yel", bus.Remaining, 5);
    measure("sel11_yel_run", 5);

    // Restart mid-count with yellow back at its default
    prog(2'b10, 4'd0);
    start(2'b00);
    no_expire("restart_no_early", 8);
    start(2'b10);
    chk("restart_rem", {bus.Busy, bus.Remaining}, {1'b1, 4'd2});
    measure("restart", 2);

    // Program strobe aborts a running count
    start(2'b00);
    cyc(5);
    prog(2'b11, 4'd1);
    chk("abort_state", {bus.expired, bus.Busy, bus.Remaining}, 0);
    no_expire("abort_no_expire", 30);

    // Start on the same edge as the final tick
    start(2'b10);
    cyc(7);
    chk("collide_pre", {bus.Busy, bus.Remaining}, {1'b1, 4'd1});
    start(2'b01);
    chk("collide_restart", {bus.expired, bus.Busy, bus.Remaining}, {1'b0, 1'b1, 4'd3});
    measure("collide_run", 3);
    cyc(1);

    // Program and start on the same edge
    bus.Prog_Sync   = 1'b1;
    bus.Sel         = 2'b11;
    bus.start_timer = 1'b1;
    bus.interval    = 2'b00;
    cyc(1);
    bus.Prog_Sync   = 1'b0;
    bus.start_timer = 1'b0;
    chk("prog_start_idle", {bus.Busy, bus.Remaining}, 0);
    cyc(3);
    chk("prog_start_stays_idle", bus.Busy, 0);

    // Interval 11 times as base
    start(2'b11);
    chk("iv11_rem", bus.Remaining, 6);
    measure("iv11", 6);

    // Asynchronous reset mid-count reverts programmed values
    prog(2'b00, 4'd9);
    prog(2'b01, 4'd7);
    prog(2'b10, 4'd8);
    start(2'b01);
    cyc(4);
    chk("prereset_busy", {bus.Busy, bus.Remaining}, {1'b1, 4'd6});
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.expired, bus.Busy, bus.Sec_Tick, bus.Remaining}, 0);
    Reset_n = 1'b1;
    cyc(1);
    start(2'b00);
    chk("reset_base_rev", bus.Remaining, 6);
    start(2'b10);
    chk("reset_yel_rev", bus.Remaining, 2);
    start(2'b01);
    chk("reset_ext_rev", bus.Remaining, 3);
    measure("reset_ext_run", 3);

    // Back-to-back: start while expired is high
    start(2'b10);
    measure("b2b_first", 2);
    chk("b2b_expired_high", bus.expired, 1);
    start(2'b10);
    chk("b2b_restart", {bus.expired, bus.Busy, bus.Remaining}, {1'b0, 1'b1, 4'd2});
    measure("b2b_second", 2);
    cyc(1);
    chk("b2b_expired_width", bus.expired, 0);

    // Maximum value
    prog(2'b00, 4'd15);
    start(2'b00);
    chk("max_rem", bus.Remaining, 15);
    measure("max", 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
